// File: rtl/cart_mem_arbiter.sv
// Shares the cartridge ROM memory port between the ROM loader and two cartridge slots,
// with loader back-pressure, per-slot CPU wait and a one-entry read cache per slot.
module cart_mem_arbiter #(
   parameter int AW      = 25,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_wr,
   input  logic [AW-1:0] ld_addr,
   input  logic [7:0]    ld_data,
   output logic          ld_wait,
   input  logic          a_rd,
   input  logic [AW-1:0] a_addr,
   output logic [7:0]    a_data,
   output logic          a_wait,
   input  logic          b_rd,
   input  logic [AW-1:0] b_addr,
   output logic [7:0]    b_data,
   output logic          b_wait,
   input  logic          flush,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_din,
   output logic          mem_we,
   output logic          mem_rd,
   input  logic [7:0]    mem_dout,
   input  logic          mem_ack,
   output logic          timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   typedef enum logic [1:0] {OWN_LD, OWN_A, OWN_B} owner_t;

   state_t          state, next_state;
   owner_t          owner, grant_owner;
   logic            grant;
   logic            ld_pend;
   logic [AW-1:0]   ld_pend_addr;
   logic [7:0]      ld_pend_data;
   logic            a_valid, b_valid;
   logic [AW-1:0]   a_tag, b_tag;
   logic [7:0]      a_byte, b_byte;
   logic            rr_b;
   logic [CW-1:0]   wait_cnt;

   logic            a_hit, b_hit, a_miss, b_miss;
   logic            ld_req;
   logic [AW-1:0]   ld_req_addr;
   logic [7:0]      ld_req_data;
   logic            done_ack, done_tmo, done;
   logic [7:0]      rd_byte;
   logic            ld_hits_a, ld_hits_b;

   assign a_hit  = a_valid && (a_tag == a_addr);
   assign b_hit  = b_valid && (b_tag == b_addr);
   assign a_miss = a_rd && !a_hit;
   assign b_miss = b_rd && !b_hit;
   assign a_wait = a_miss;
   assign b_wait = b_miss;
   assign a_data = a_byte;
   assign b_data = b_byte;
   assign ld_wait = ld_pend;

   // A write strobe in the same cycle competes immediately so the loader never loses to a slot
   assign ld_req      = ld_pend || ld_wr;
   assign ld_req_addr = ld_pend ? ld_pend_addr : ld_addr;
   assign ld_req_data = ld_pend ? ld_pend_data : ld_data;

   assign done_ack = (state == WAIT) && mem_ack;
   assign done_tmo = (state == WAIT) && !mem_ack && (wait_cnt == CW'(TIMEOUT - 1));
   assign done     = done_ack || done_tmo;
   assign rd_byte  = done_ack ? mem_dout : 8'hFF;

   assign ld_hits_a = grant && (grant_owner == OWN_LD) && a_valid && (a_tag == ld_req_addr);
   assign ld_hits_b = grant && (grant_owner == OWN_LD) && b_valid && (b_tag == ld_req_addr);

   assign mem_we = (state == ISSUE) && (owner == OWN_LD);
   assign mem_rd = (state == ISSUE) && (owner != OWN_LD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Loader first, then round-robin between missing slots; a lone miss wins regardless of pointer
   always_comb begin
      next_state  = state;
      grant       = 1'b0;
      grant_owner = OWN_LD;
      case (state)
         IDLE: begin
            if (ld_req) begin
               grant = 1'b1;
            end else if (a_miss && (!b_miss || !rr_b)) begin
               grant       = 1'b1;
               grant_owner = OWN_A;
            end else if (b_miss) begin
               grant       = 1'b1;
               grant_owner = OWN_B;
            end
            if (grant) next_state = ISSUE;
         end
         ISSUE:   next_state = WAIT;
         WAIT:    if (done) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ld_pend      <= 1'b0;
         ld_pend_addr <= '0;
         ld_pend_data <= '0;
         a_valid      <= 1'b0;
         b_valid      <= 1'b0;
         a_tag        <= '0;
         b_tag        <= '0;
         a_byte       <= 8'hFF;
         b_byte       <= 8'hFF;
         rr_b         <= 1'b0;
         owner        <= OWN_LD;
         mem_addr     <= '0;
         mem_din      <= '0;
         wait_cnt     <= '0;
         timeout_err  <= 1'b0;
      end else begin
         if (done && owner == OWN_LD) begin
            ld_pend <= 1'b0;
         end else if (ld_wr && !ld_pend) begin
            ld_pend      <= 1'b1;
            ld_pend_addr <= ld_addr;
            ld_pend_data <= ld_data;
         end

         if (grant) begin
            owner <= grant_owner;
            case (grant_owner)
               OWN_A: begin
                  mem_addr <= a_addr;
                  rr_b     <= 1'b1;
               end
               OWN_B: begin
                  mem_addr <= b_addr;
                  rr_b     <= 1'b0;
               end
               default: begin
                  mem_addr <= ld_req_addr;
                  mem_din  <= ld_req_data;
               end
            endcase
         end

         if (state == ISSUE)              wait_cnt <= '0;
         else if (state == WAIT && !done) wait_cnt <= wait_cnt + 1'b1;
         if (done_tmo) timeout_err <= 1'b1;

         // Flush beats a simultaneous fill so the slot re-requests fresh data
         if (done && owner == OWN_A) begin
            a_tag  <= mem_addr;
            a_byte <= rd_byte;
         end
         if (flush || ld_hits_a)          a_valid <= 1'b0;
         else if (done && owner == OWN_A) a_valid <= 1'b1;

         if (done && owner == OWN_B) begin
            b_tag  <= mem_addr;
            b_byte <= rd_byte;
         end
         if (flush || ld_hits_b)          b_valid <= 1'b0;
         else if (done && owner == OWN_B) b_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Scoreboard bench for cart_mem_arbiter: expected memory commands are queued as stimulus is
// driven and popped by the memory model when the arbiter issues them.
module tb_cart_mem_arbiter;

   localparam int AW      = 25;
   localparam int TIMEOUT = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          ld_wr;
   logic [AW-1:0] ld_addr;
   logic [7:0]    ld_data;
   logic          ld_wait;
   logic          a_rd, b_rd;
   logic [AW-1:0] a_addr, b_addr;
   logic [7:0]    a_data, b_data;
   logic          a_wait, b_wait;
   logic          flush;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic          mem_we, mem_rd;
   logic [7:0]    mem_dout = 8'h00;
   logic          mem_ack = 1'b0;
   logic          timeout_err;

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } cmd_t;

   cmd_t       exp_q[$];
   logic [7:0] mem_model [int];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         ack_cyc = -1;
   int         cmd_cyc = -1;
   int         rd_count = 0;
   int         we_count = 0;
   int         ack_countdown = -1;
   int         ack_delay = 3;
   bit         ack_enable = 1'b1;
   logic [7:0] ack_data = 8'h00;

   cart_mem_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_wait(ld_wait),
      .a_rd(a_rd), .a_addr(a_addr), .a_data(a_data), .a_wait(a_wait),
      .b_rd(b_rd), .b_addr(b_addr), .b_data(b_data), .b_wait(b_wait),
      .flush(flush),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
      .mem_dout(mem_dout), .mem_ack(mem_ack), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [7:0] read_model(input int a);
      if (mem_model.exists(a)) return mem_model[a];
      return 8'(a[7:0] ^ a[15:8] ^ 8'h3C);
   endfunction

   task automatic expect_cmd(input bit we, input int addr, input logic [7:0] data);
      exp_q.push_back('{we: we, addr: AW'(addr), data: data});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory model: acks ack_delay cycles after each command and checks commands against the queue
   initial forever begin
      cmd_t e;
      @(negedge clk);
      mem_ack = 1'b0;
      if (ack_countdown == 0) begin
         mem_ack       = 1'b1;
         mem_dout      = ack_data;
         ack_cyc       = cyc;
         ack_countdown = -1;
      end else if (ack_countdown > 0) begin
         ack_countdown--;
      end
      if (mem_we || mem_rd) begin
         cmd_cyc = cyc;
         if (mem_rd) rd_count++;
         else        we_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_cmd: got we=%0b addr=%h, expected no command", mem_we, mem_addr);
         end else begin
            e = exp_q.pop_front();
            if (e.we !== mem_we || e.addr !== mem_addr || (mem_we && e.data !== mem_din)) begin
               errors++;
               $display("[TB] FAIL cmd_order: got we=%0b addr=%h din=%h, expected we=%0b addr=%h din=%h",
                        mem_we, mem_addr, mem_din, e.we, e.addr, e.data);
            end
         end
         if (mem_we) mem_model[int'(mem_addr)] = mem_din;
         else        ack_data = read_model(int'(mem_addr));
         if (ack_enable) ack_countdown = ack_delay - 1;
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic test_reset();
      step();
      checks++; if (ld_wait !== 1'b0) begin errors++; $display("[TB] FAIL rst_ld_wait: got %b expected 0", ld_wait); end
      checks++; if (a_wait !== 1'b0 || b_wait !== 1'b0) begin errors++; $display("[TB] FAIL rst_wait: got %b%b expected 00", a_wait, b_wait); end
      checks++; if (a_data !== 8'hFF || b_data !== 8'hFF) begin errors++; $display("[TB] FAIL rst_data: got %h %h expected ff ff", a_data, b_data); end
      checks++; if (mem_we !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL rst_cmd: got we=%b rd=%b expected 0 0", mem_we, mem_rd); end
      checks++; if (mem_addr !== '0 || mem_din !== 8'h00) begin errors++; $display("[TB] FAIL rst_mem_bus: got %h %h expected 0 0", mem_addr, mem_din); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_timeout_err: got %b expected 0", timeout_err); end
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_loader_burst();
      logic [7:0] d;
      for (int i = 0; i < 4; i++) begin
         d = 8'(8'h11 * (i + 1));
         expect_cmd(1'b1, i, d);
         ack_cyc = -1;
         ld_wr = 1'b1; ld_addr = AW'(i); ld_data = d;
         step();
         ld_wr = 1'b0;
         checks++; if (ld_wait !== 1'b1) begin errors++; $display("[TB] FAIL ld_wait_set[%0d]: got %b expected 1", i, ld_wait); end
         for (int k = 0; k < 40 && ld_wait; k++) step();
         checks++;
         if (ld_wait !== 1'b0 || ack_cyc != cyc - 1) begin
            errors++;
            $display("[TB] FAIL ld_wait_release[%0d]: got ld_wait=%b at cycle %0d, expected 0 at ack cycle %0d + 1", i, ld_wait, cyc, ack_cyc);
         end
      end
      checks++; if (we_count != 4 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL ld_burst_count: got %0d writes, %0d left, expected 4, 0", we_count, exp_q.size()); end
   endtask

   task automatic test_miss_hit();
      int rd0, req_c;
      mem_model[32'h4010] = 8'h5A;
      rd0 = rd_count;
      ack_cyc = -1;
      expect_cmd(1'b0, 32'h4010, 8'h00);
      req_c = cyc;
      a_rd = 1'b1; a_addr = AW'(32'h4010);
      #1;
      checks++; if (a_wait !== 1'b1) begin errors++; $display("[TB] FAIL miss_wait: got %b expected 1", a_wait); end
      for (int k = 0; k < 40 && a_wait; k++) step();
      checks++; if (a_wait !== 1'b0 || ack_cyc != cyc - 1) begin errors++; $display("[TB] FAIL miss_fall: got a_wait=%b cycle %0d, expected 0 at ack %0d + 1", a_wait, cyc, ack_cyc); end
      checks++; if (cmd_cyc != req_c + 1) begin errors++; $display("[TB] FAIL miss_latency: got mem_rd cycle %0d expected %0d", cmd_cyc, req_c + 1); end
      checks++; if (a_data !== 8'h5A) begin errors++; $display("[TB] FAIL miss_data: got %h expected 5a", a_data); end
      a_rd = 1'b0;
      step();
      a_rd = 1'b1;
      #1;
      checks++; if (a_wait !== 1'b0 || a_data !== 8'h5A) begin errors++; $display("[TB] FAIL hit: got wait=%b data=%h expected 0 5a", a_wait, a_data); end
      repeat (5) step();
      checks++; if (rd_count != rd0 + 1) begin errors++; $display("[TB] FAIL hit_no_rd: got %0d reads expected %0d", rd_count - rd0, 1); end
      a_rd = 1'b0;
      step();
   endtask

   task automatic test_contention();
      do_reset();
      expect_cmd(1'b1, 32'h200, 8'h77);
      expect_cmd(1'b0, 32'h300, 8'h00);
      expect_cmd(1'b0, 32'h400, 8'h00);
      ld_wr = 1'b1; ld_addr = AW'(32'h200); ld_data = 8'h77;
      a_rd = 1'b1; a_addr = AW'(32'h300);
      b_rd = 1'b1; b_addr = AW'(32'h400);
      step();
      ld_wr = 1'b0;
      for (int k = 0; k < 80 && (a_wait || b_wait); k++) step();
      checks++; if (a_data !== read_model(32'h300) || b_data !== read_model(32'h400)) begin errors++; $display("[TB] FAIL cont_data: got %h %h expected %h %h", a_data, b_data, read_model(32'h300), read_model(32'h400)); end
      checks++; if (exp_q.size() != 0 || a_wait || b_wait) begin errors++; $display("[TB] FAIL cont_done: got %0d cmds left, waits %b%b, expected 0, 00", exp_q.size(), a_wait, b_wait); end
      a_rd = 1'b0; b_rd = 1'b0;
      step();
      // a lone A miss moves the pointer to B, so the next dual miss serves B first
      expect_cmd(1'b0, 32'h310, 8'h00);
      a_rd = 1'b1; a_addr = AW'(32'h310);
      step();
      for (int k = 0; k < 40 && a_wait; k++) step();
      a_rd = 1'b0;
      step();
      expect_cmd(1'b0, 32'h420, 8'h00);
      expect_cmd(1'b0, 32'h320, 8'h00);
      a_rd = 1'b1; a_addr = AW'(32'h320);
      b_rd = 1'b1; b_addr = AW'(32'h420);
      step();
      for (int k = 0; k < 80 && (a_wait || b_wait); k++) step();
      checks++; if (a_data !== read_model(32'h320) || b_data !== read_model(32'h420)) begin errors++; $display("[TB] FAIL rr_data: got %h %h expected %h %h", a_data, b_data, read_model(32'h320), read_model(32'h420)); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL rr_done: got %0d cmds left expected 0", exp_q.size()); end
      a_rd = 1'b0; b_rd = 1'b0;
      step();
   endtask

   task automatic test_flush_invalidate();
      mem_model[32'h100] = 8'h12;
      expect_cmd(1'b0, 32'h100, 8'h00);
      a_rd = 1'b1; a_addr = AW'(32'h100);
      step();
      for (int k = 0; k < 40 && a_wait; k++) step();
      checks++; if (a_data !== 8'h12 || a_wait) begin errors++; $display("[TB] FAIL fill_0100: got %h wait=%b expected 12 0", a_data, a_wait); end
      a_rd = 1'b0;
      expect_cmd(1'b1, 32'h100, 8'h34);
      ld_wr = 1'b1; ld_addr = AW'(32'h100); ld_data = 8'h34;
      step();
      ld_wr = 1'b0;
      for (int k = 0; k < 40 && ld_wait; k++) step();
      expect_cmd(1'b0, 32'h100, 8'h00);
      a_rd = 1'b1;
      #1;
      checks++; if (a_wait !== 1'b1) begin errors++; $display("[TB] FAIL ld_invalidate: got a_wait=%b expected 1", a_wait); end
      for (int k = 0; k < 40 && a_wait; k++) step();
      checks++; if (a_data !== 8'h34) begin errors++; $display("[TB] FAIL refill_data: got %h expected 34", a_data); end
      a_rd = 1'b0;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      expect_cmd(1'b0, 32'h100, 8'h00);
      a_rd = 1'b1;
      #1;
      checks++; if (a_wait !== 1'b1) begin errors++; $display("[TB] FAIL flush_invalidate: got a_wait=%b expected 1", a_wait); end
      for (int k = 0; k < 40 && a_wait; k++) step();
      checks++; if (a_data !== 8'h34 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL flush_refill: got %h with %0d cmds left, expected 34 with 0", a_data, exp_q.size()); end
      a_rd = 1'b0;
      step();
   endtask

   task automatic test_timeout();
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_pre: got %b expected 0", timeout_err); end
      ack_enable = 1'b0;
      cmd_cyc = -1;
      expect_cmd(1'b0, 32'h500, 8'h00);
      b_rd = 1'b1; b_addr = AW'(32'h500);
      step();
      for (int k = 0; k < TIMEOUT + 20 && b_wait; k++) step();
      checks++; if (b_wait !== 1'b0 || cyc != cmd_cyc + TIMEOUT + 1) begin errors++; $display("[TB] FAIL tmo_release: got b_wait=%b at cycle %0d expected 0 at %0d", b_wait, cyc, cmd_cyc + TIMEOUT + 1); end
      checks++; if (b_data !== 8'hFF) begin errors++; $display("[TB] FAIL tmo_data: got %h expected ff", b_data); end
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL tmo_err: got %b expected 1", timeout_err); end
      b_rd = 1'b0;
      repeat (3) step();
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL tmo_sticky: got %b expected 1", timeout_err); end
      ack_enable = 1'b1;
   endtask

   task automatic test_reset_mid();
      int rd0;
      ack_delay = 6;
      ack_cyc = -1;
      rd0 = rd_count;
      expect_cmd(1'b0, 32'h600, 8'h00);
      a_rd = 1'b1; a_addr = AW'(32'h600);
      for (int k = 0; k < 10 && rd_count == rd0; k++) step();
      checks++; if (rd_count != rd0 + 1) begin errors++; $display("[TB] FAIL rmid_issue: got %0d reads expected 1", rd_count - rd0); end
      step();
      reset = 1'b1; a_rd = 1'b0;
      #1;
      checks++; if (ld_wait !== 1'b0 || a_wait !== 1'b0 || b_wait !== 1'b0) begin errors++; $display("[TB] FAIL rmid_waits: got %b%b%b expected 000", ld_wait, a_wait, b_wait); end
      checks++; if (a_data !== 8'hFF || b_data !== 8'hFF) begin errors++; $display("[TB] FAIL rmid_data: got %h %h expected ff ff", a_data, b_data); end
      checks++; if (mem_we !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== '0 || mem_din !== 8'h00) begin errors++; $display("[TB] FAIL rmid_mem: got we=%b rd=%b addr=%h din=%h expected all 0", mem_we, mem_rd, mem_addr, mem_din); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL rmid_timeout_err: got %b expected 0", timeout_err); end
      step();
      step();
      reset = 1'b0;
      for (int k = 0; k < 20 && ack_cyc < 0; k++) step();
      checks++; if (ack_cyc < 0) begin errors++; $display("[TB] FAIL rmid_late_ack: got no ack expected one"); end
      step();
      expect_cmd(1'b0, 32'h600, 8'h00);
      a_rd = 1'b1;
      #1;
      checks++; if (a_wait !== 1'b1) begin errors++; $display("[TB] FAIL rmid_no_fill: got a_wait=%b expected 1", a_wait); end
      for (int k = 0; k < 40 && a_wait; k++) step();
      checks++; if (a_data !== read_model(32'h600) || exp_q.size() != 0) begin errors++; $display("[TB] FAIL rmid_fresh_rd: got %h with %0d cmds left, expected %h with 0", a_data, exp_q.size(), read_model(32'h600)); end
      a_rd = 1'b0;
      ack_delay = 3;
      step();
   endtask

   initial begin
      reset = 1'b1;
      ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
      a_rd = 1'b0; a_addr = '0;
      b_rd = 1'b0; b_addr = '0;
      flush = 1'b0;
      test_reset();
      test_loader_burst();
      test_miss_hit();
      test_contention();
      test_flush_invalidate();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cart_mem_arbiter.md
Name: cart_mem_arbiter

Overview:
- Sequences and shares the single cartridge ROM memory port (SDRAM controller command interface) between three requesters:
  - the ROM loader (ioctl write stream);
  - cartridge slot A CPU reads;
  - cartridge slot B CPU reads.
- Sits between the per-slot mapper address logic and the SDRAM controller.
- Generates loader back-pressure and per-slot CPU wait.
- Keeps a one-entry read cache per slot so repeated reads of the same byte do not reissue memory cycles.

Parameters:
- AW, 25, byte address width of memory port and all requester addresses.
- TIMEOUT, 64, max cycles to wait for mem_ack before aborting an access.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ld_wr  in  1  loader byte-write strobe, one-cycle pulse.
- ld_addr  in  AW  loader byte address.
- ld_data  in  8  loader byte.
- ld_wait  out  1  loader must hold off further ld_wr while high.
- a_rd  in  1  slot A read request, level; held while the CPU read cycle is active.
- a_addr  in  AW  slot A mapped address.
- a_data  out  8  slot A read data.
- a_wait  out  1  slot A data not yet valid.
- b_rd, b_addr, b_data, b_wait  same as slot A, for slot B.
- flush  in  1  one-cycle pulse; invalidates both read caches (mapper bank switch, new ROM load).
- mem_addr  out  AW  memory address.
- mem_din  out  8  memory write data.
- mem_we  out  1  write command, one-cycle pulse.
- mem_rd  out  1  read command, one-cycle pulse.
- mem_dout  in  8  memory read data, valid when mem_ack=1.
- mem_ack  in  1  one-cycle completion pulse.
- timeout_err  out  1  sticky; set on any access timeout, cleared only by reset.

Behaviour:
- Reset values:
  - ld_wait=0, a_wait=0, b_wait=0, a_data=b_data=8'hFF.
  - mem_we=mem_rd=0, mem_addr=0, mem_din=0, timeout_err=0.
  - Both cache-valid bits cleared, round-robin pointer=A, FSM=IDLE.
- Loader request capture:
  - ld_wr latches ld_addr/ld_data into a pending register and sets ld_wait=1 in the next cycle.
  - ld_wait stays 1 until the write's mem_ack (or timeout), then drops to 0 in the cycle after completion.
  - ld_wr while the pending register is full is ignored (protocol violation; not required to be handled).
- Slot hit:
  - a_rd=1 with cache valid and cached address == a_addr → a_data = cached byte, a_wait=0 combinationally from registered state.
  - No memory cycle is issued.
- Slot miss:
  - a_rd=1 otherwise → a_wait=1 (combinational) until the fill completes.
  - Same rules apply to slot B.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE arbitration, evaluated each cycle:
  - Pending loader write has absolute priority.
  - Between slot misses, use round-robin. The pointer toggles to the other slot after each slot access is granted.
  - When only one slot misses, it wins regardless of the pointer.
- ISSUE (1 cycle):
  - Drive mem_addr/mem_din from the winner.
  - Pulse mem_we (loader) or mem_rd (slot).
  - Clear the timeout counter.
  - Go to WAIT.
- WAIT:
  - Count cycles. On mem_ack, return to IDLE.
  - For a slot read: load the slot cache with {address, mem_dout}, set valid, and drive slot data.
  - On the write path: clear ld_wait in the following cycle.
  - If the count reaches TIMEOUT-1 without ack: set timeout_err, complete the access with data 8'hFF (slot cache filled with FF, valid), release wait, return to IDLE.
- Latency:
  - Miss in IDLE with no contention: mem_rd one cycle after the request is seen.
  - a_wait falls the cycle after mem_ack.
- Loader and cache interaction:
  - A loader write whose address matches a slot's cached address invalidates that slot's cache at grant time.
  - flush invalidates both caches immediately.
  - If flush coincides with a fill completion, flush wins: cache ends invalid and the slot re-requests.
- Slot request withdrawn mid-access:
  - If a_rd drops while its read is in WAIT, the access still completes and fills the cache.
  - No abort to memory.
- mem_ack arriving in IDLE or ISSUE is ignored.
- Asynchronous reset mid-access:
  - All state returns to reset values immediately.
  - An outstanding memory command is abandoned.
  - Stray mem_ack after reset is ignored per the previous rule.

Test Plan:
- Loader burst:
  - Stimulus: 4 ld_wr at addr 0..3, data 11,22,33,44; memory model acks 3 cycles after each command.
  - Required: 4 mem_we pulses in order with matching addr/data; ld_wait high from cycle after each ld_wr until cycle after its ack.
- Slot A miss then hit:
  - Stimulus: a_rd with a_addr=0x4010; memory returns 0x5A.
  - Required: exactly one mem_rd; a_wait falls cycle after ack with a_data=0x5A. A second a_rd at 0x4010 gives a_wait=0 and no mem_rd.
- Contention:
  - Stimulus: a_rd, b_rd and ld_wr all in the same cycle, all misses.
  - Required: service order loader, A, B. Repeating with only A and B pending alternates starting from the pointer value.
- Flush and loader invalidate:
  - Stimulus: fill A at 0x0100; then ld_wr to 0x0100; then a_rd 0x0100.
  - Required: a new mem_rd is issued. Separately, flush followed by a_rd of a cached address also reissues.
- Timeout:
  - Stimulus: memory model never acks a slot B read.
  - Required: after TIMEOUT cycles in WAIT, b_data=8'hFF, b_wait=0, timeout_err=1 and stays 1.
- Reset mid-access:
  - Stimulus: assert reset during WAIT, then deliver a late mem_ack.
  - Required: all outputs at reset values immediately; late ack causes no cache fill; the next a_rd issues a fresh mem_rd.
